uhf_tx_byte_serializer: RTL and testbench
=========================================

Name: uhf_tx_byte_serializer

Overview:
Downstream consumer of the UHF TX SRAM read port. On a start pulse it transmits PREAMBLE_LEN bytes of 0xAA, then i_frame_length payload bytes fetched one at a time from SRAM addresses 0..len-1. Payload is fetched through the read handshake (start_read / read_data_ready / Reset_Read) and serialized MSB-first at one bit per BIT_PERIOD clocks. Output feeds the UHF modulator bit input and PTT enable.

Parameters:
BIT_PERIOD, 16, i_PCLK cycles per transmitted bit (legal range 4..65535)
PREAMBLE_LEN, 4, number of 0xAA preamble bytes (legal range 0..255)
READ_TIMEOUT, 64, max cycles from fetch request to read_data_ready before abort
PTR_W, 13, byte pointer width

Ports:
i_PCLK  in  1  clock, the only clock; all logic on rising edge
i_Reset_all  in  1  synchronous, active-high reset
i_tx_start  in  1  one-cycle start request
i_frame_length  in  PTR_W  payload byte count, sampled at accepted start
i_write_busy  in  1  SRAM writer active (from o_apb_write_busy); start is refused while high
o_start_read  out  1  read request to SRAM interface
o_byte_read_pointer  out  PTR_W  SRAM byte address; stable while o_start_read=1
o_Reset_Read  out  1  active-low clear of read_data_ready in SRAM interface
i_read_data_ready  in  1  fetched byte valid (set on falling edge by SRAM interface)
i_read_data  in  8  fetched byte
o_tx_bit  out  1  serial bit to modulator
o_tx_enable  out  1  PTT / bit-valid, high for the whole frame
o_busy  out  1  high from accepted start until done/error
o_done  out  1  one-cycle pulse after last bit period completes
o_error  out  1  one-cycle pulse on fetch timeout or underrun; frame aborted

Behaviour:
- Reset (i_Reset_all=1 at a rising edge): all outputs 0, including o_Reset_Read=0 (holds SRAM ready flag cleared). FSMs go to IDLE, counters 0. Reset mid-frame aborts without o_done/o_error.
- Start is accepted when IDLE, i_tx_start=1, i_write_busy=0 and i_frame_length!=0. Otherwise it is ignored with no pulse.
- TX FSM states: IDLE -> PREAMBLE (skipped if PREAMBLE_LEN=0) -> PAYLOAD -> DONE -> IDLE. DONE lasts 1 cycle and asserts o_done.
- Cycle after an accepted start: o_busy=1, o_tx_enable=1, o_tx_bit = MSB of first byte. Each bit is held exactly BIT_PERIOD cycles.
- Bit timer counts 0..BIT_PERIOD-1. At terminal count the shifter advances; after bit 0 of a byte, the next byte loads from the prefetch register.
- After the last payload bit period: o_tx_enable=0, o_tx_bit=0, o_done=1 for one cycle, o_busy=0 on the following cycle.
- Total enable time = (PREAMBLE_LEN+len)*8*BIT_PERIOD cycles.
- Fetch FSM states and transitions:
  - F_IDLE: waits for prefetch register empty and pointer < len.
  - F_REQ: o_Reset_Read=1, o_start_read=1, pointer held. On i_read_data_ready=1: capture i_read_data, mark prefetch full, go to F_CLR.
  - F_CLR: one cycle with o_start_read=0, o_Reset_Read=0, pointer+1, then back to F_IDLE.
- The first fetch starts in the cycle after start, in parallel with the preamble.
- Timeout: cycle count in F_REQ reaching READ_TIMEOUT produces o_error and abort.
- Underrun: a byte boundary with an empty prefetch register also produces o_error and abort.
- Abort sequence: next cycle all outputs 0, return to IDLE, no o_done.
- Pointer arithmetic is unsigned PTR_W bits. len=8191 fetches addresses 0..8190; the pointer never wraps within a frame.
- i_tx_start while busy is ignored. A start in the o_done cycle is ignored; a start one cycle later is accepted.
- Changes on i_frame_length or i_write_busy mid-frame have no effect.

Decomposition:
- Shared package uhf_tx_pkg: TX and fetch state encodings, PREAMBLE_BYTE=8'hAA, PTR_W default.
- One sub-module, uhf_tx_bit_shifter: bit timer, 8-bit shift register, load/advance strobes, byte_boundary flag.

Test Plan:
- BIT_PERIOD=4, PREAMBLE_LEN=2, len=2, SRAM model bytes 0x5A,0xC3 -> stream AA AA 5A C3 MSB-first; o_tx_enable high 128 cycles; o_done 1 cycle; addresses 0,1 requested once each.
- SRAM model never asserts ready, READ_TIMEOUT=64 -> o_error exactly 64 cycles after o_start_read rises; o_tx_enable drops the next cycle; no o_done.
- Start with i_write_busy=1, then with len=0 -> both ignored: o_busy stays 0, no pulses, no read requests.
- Reset asserted mid-payload (byte 1, bit 3) -> all outputs 0 the next cycle; a fresh start afterwards retransmits from address 0.
- Start pulsed again while busy, then in the o_done cycle, then one cycle after -> first two ignored, third starts a new identical frame.
- BIT_PERIOD=4, ready delayed 40 cycles on byte 1 -> underrun o_error at the byte-0/1 boundary, abort.

Source files
------------

// File: rtl/uhf_tx_pkg.sv
// Shared encodings and constants for the UHF TX byte serializer.
package uhf_tx_pkg;

  localparam int         PTR_W_DEFAULT = 13;
  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    TX_IDLE     = 3'd0,
    TX_PREAMBLE = 3'd1,
    TX_PAYLOAD  = 3'd2,
    TX_DONE     = 3'd3,
    TX_ABORT    = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_CLR  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/uhf_tx_bit_shifter.sv
// Bit timer plus MSB-first shift register; flags the end of the eighth bit period.
module uhf_tx_bit_shifter #(
  parameter int BIT_PERIOD = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [7:0] load_byte_i,
  input  logic       run_i,
  output logic       bit_o,
  output logic       byte_boundary_o
);

  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);

  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    sr_q;
  logic          terminal_s;

  assign terminal_s      = run_i && (timer_q == T_LAST);
  assign byte_boundary_o = terminal_s && (bit_idx_q == 3'd7);
  assign bit_o           = sr_q[7];

  // Timer and shifter; a load at a byte boundary takes priority over the idle hold on bit 7.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      sr_q      <= 8'd0;
    end else if (load_i) begin
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      sr_q      <= load_byte_i;
    end else if (terminal_s) begin
      timer_q <= '0;
      if (bit_idx_q != 3'd7) begin
        sr_q      <= {sr_q[6:0], 1'b0};
        bit_idx_q <= bit_idx_q + 3'd1;
      end
    end else if (run_i) begin
      timer_q <= timer_q + TW'(1);
    end
  end

endmodule

// File: rtl/uhf_tx_byte_serializer.sv
// Frame serializer: 0xAA preamble then SRAM payload, prefetched one byte ahead of the shifter.
module uhf_tx_byte_serializer
  import uhf_tx_pkg::*;
#(
  parameter int BIT_PERIOD   = 16,
  parameter int PREAMBLE_LEN = 4,
  parameter int READ_TIMEOUT = 64,
  parameter int PTR_W        = PTR_W_DEFAULT
) (
  input  logic             i_PCLK,
  input  logic             i_Reset_all,
  input  logic             i_tx_start,
  input  logic [PTR_W-1:0] i_frame_length,
  input  logic             i_write_busy,
  output logic             o_start_read,
  output logic [PTR_W-1:0] o_byte_read_pointer,
  output logic             o_Reset_Read,
  input  logic             i_read_data_ready,
  input  logic [7:0]       i_read_data,
  output logic             o_tx_bit,
  output logic             o_tx_enable,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error
);

  localparam int              TMO_W    = $clog2(READ_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(READ_TIMEOUT - 1);
  localparam logic [7:0]      PRE_LAST = 8'(PREAMBLE_LEN - 1);

  tx_state_e    tx_state_q;
  fetch_state_e fetch_state_q;
  logic [PTR_W-1:0] len_q, ptr_q, pay_cnt_q;
  logic [7:0]       pre_cnt_q, pf_data_q;
  logic [TMO_W-1:0] tmo_q;
  logic pf_full_q, en_q, busy_q, done_q, err_q, sreq_q, rr_q;

  logic accept_s, timeout_s, abort_s, run_s, fetch_active_s;
  logic load_s, consume_s, underrun_s, last_s, clear_s, boundary_s, tx_bit_s;
  logic [7:0] load_byte_s;

  assign accept_s       = (tx_state_q == TX_IDLE) && i_tx_start && !i_write_busy
                          && (i_frame_length != '0);
  assign timeout_s      = (fetch_state_q == F_REQ) && !i_read_data_ready && (tmo_q == TMO_LAST);
  assign abort_s        = underrun_s || timeout_s;
  assign fetch_active_s = (tx_state_q == TX_PREAMBLE) || (tx_state_q == TX_PAYLOAD);
  assign run_s          = (tx_state_q == TX_PREAMBLE) || ((tx_state_q == TX_PAYLOAD) && en_q);

  // Byte-boundary decisions: next preamble byte, prefetched payload byte, end of frame or underrun.
  always_comb begin
    load_s      = 1'b0;
    load_byte_s = PREAMBLE_BYTE;
    consume_s   = 1'b0;
    underrun_s  = 1'b0;
    last_s      = 1'b0;
    clear_s     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (accept_s && (PREAMBLE_LEN > 0)) load_s = 1'b1;
        else                                load_s = 1'b0;
      end
      TX_PREAMBLE: begin
        if (boundary_s && (pre_cnt_q != PRE_LAST)) begin
          load_s = 1'b1;
        end else if (boundary_s && pf_full_q) begin
          load_s      = 1'b1;
          load_byte_s = pf_data_q;
          consume_s   = 1'b1;
        end else if (boundary_s) begin
          underrun_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      TX_PAYLOAD: begin
        // With no preamble the first payload byte is awaited before enabling the output.
        if (!en_q && pf_full_q) begin
          load_s      = 1'b1;
          load_byte_s = pf_data_q;
          consume_s   = 1'b1;
        end else if (boundary_s && (pay_cnt_q == len_q)) begin
          last_s  = 1'b1;
          clear_s = 1'b1;
        end else if (boundary_s && pf_full_q) begin
          load_s      = 1'b1;
          load_byte_s = pf_data_q;
          consume_s   = 1'b1;
        end else if (boundary_s) begin
          underrun_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      TX_DONE, TX_ABORT: clear_s = 1'b1;
      default:           clear_s = 1'b1;
    endcase
  end

  // TX frame FSM with registered status outputs.
  always_ff @(posedge i_PCLK) begin
    if (i_Reset_all) begin
      tx_state_q <= TX_IDLE;
      len_q      <= '0;
      pre_cnt_q  <= 8'd0;
      pay_cnt_q  <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (accept_s) begin
            len_q      <= i_frame_length;
            pre_cnt_q  <= 8'd0;
            pay_cnt_q  <= '0;
            busy_q     <= 1'b1;
            en_q       <= (PREAMBLE_LEN > 0);
            tx_state_q <= (PREAMBLE_LEN > 0) ? TX_PREAMBLE : TX_PAYLOAD;
          end
        end
        TX_PREAMBLE: begin
          if (abort_s) begin
            tx_state_q <= TX_ABORT;
            err_q      <= 1'b1;
          end else if (boundary_s && (pre_cnt_q == PRE_LAST)) begin
            tx_state_q <= TX_PAYLOAD;
          end else if (boundary_s) begin
            pre_cnt_q <= pre_cnt_q + 8'd1;
          end
        end
        TX_PAYLOAD: begin
          if (abort_s) begin
            tx_state_q <= TX_ABORT;
            err_q      <= 1'b1;
          end else if (last_s) begin
            tx_state_q <= TX_DONE;
            en_q       <= 1'b0;
            done_q     <= 1'b1;
          end else if (load_s) begin
            en_q <= 1'b1;
          end
        end
        TX_DONE: begin
          tx_state_q <= TX_IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
        end
        TX_ABORT: begin
          tx_state_q <= TX_IDLE;
          err_q      <= 1'b0;
          busy_q     <= 1'b0;
          en_q       <= 1'b0;
        end
        default: begin
          tx_state_q <= TX_IDLE;
          en_q       <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
        end
      endcase
      if (consume_s) pay_cnt_q <= pay_cnt_q + PTR_W'(1);
    end
  end

  // Fetch FSM: one outstanding SRAM read into a single-byte prefetch register.
  always_ff @(posedge i_PCLK) begin
    if (i_Reset_all || abort_s || last_s) begin
      fetch_state_q <= F_IDLE;
      ptr_q         <= '0;
      pf_data_q     <= 8'd0;
      pf_full_q     <= 1'b0;
      tmo_q         <= '0;
      sreq_q        <= 1'b0;
      rr_q          <= 1'b0;
    end else if (accept_s) begin
      fetch_state_q <= F_REQ;
      ptr_q         <= '0;
      pf_full_q     <= 1'b0;
      tmo_q         <= '0;
      sreq_q        <= 1'b1;
      rr_q          <= 1'b1;
    end else begin
      if (consume_s) pf_full_q <= 1'b0;
      case (fetch_state_q)
        F_IDLE: begin
          if (fetch_active_s && !pf_full_q && (ptr_q < len_q)) begin
            fetch_state_q <= F_REQ;
            tmo_q         <= '0;
            sreq_q        <= 1'b1;
            rr_q          <= 1'b1;
          end
        end
        F_REQ: begin
          if (i_read_data_ready) begin
            fetch_state_q <= F_CLR;
            pf_data_q     <= i_read_data;
            pf_full_q     <= 1'b1;
            sreq_q        <= 1'b0;
            rr_q          <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        F_CLR: begin
          fetch_state_q <= F_IDLE;
          ptr_q         <= ptr_q + PTR_W'(1);
        end
        default: begin
          fetch_state_q <= F_IDLE;
          sreq_q        <= 1'b0;
          rr_q          <= 1'b0;
        end
      endcase
    end
  end

  uhf_tx_bit_shifter #(.BIT_PERIOD(BIT_PERIOD)) u_shifter (
    .clk_i           (i_PCLK),
    .rst_i           (i_Reset_all),
    .clear_i         (clear_s),
    .load_i          (load_s),
    .load_byte_i     (load_byte_s),
    .run_i           (run_s),
    .bit_o           (tx_bit_s),
    .byte_boundary_o (boundary_s)
  );

  assign o_start_read        = sreq_q;
  assign o_Reset_Read        = rr_q;
  assign o_byte_read_pointer = ptr_q;
  assign o_tx_bit            = tx_bit_s;
  assign o_tx_enable         = en_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_error             = err_q;

endmodule

// File: tb/tb_uhf_tx_byte_serializer.sv
// Directed bench for uhf_tx_byte_serializer with a negedge SRAM read-port model.
module tb_uhf_tx_byte_serializer;

  localparam int PTR_W = 13;

  logic clk = 1'b0;
  logic rst, start, wbusy;
  logic [PTR_W-1:0] len, ptr;
  logic rdy = 1'b0;
  logic [7:0] rdata = 8'd0;
  logic sreq, rr, tx_bit, tx_en, busy, done, err;
  logic [19:0] outs;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_err    = 0;
  int rcnt     = 0;
  int dly1     = 1;
  bit no_ready = 1'b0;
  logic sreq_prev = 1'b0;
  int req_q[$];
  bit bits_q[$];
  logic [7:0] mem [0:1] = '{8'h5A, 8'hC3};

  assign outs = {sreq, ptr, rr, tx_bit, tx_en, busy, done, err};

  uhf_tx_byte_serializer #(
    .BIT_PERIOD(4), .PREAMBLE_LEN(2), .READ_TIMEOUT(64), .PTR_W(PTR_W)
  ) dut (
    .i_PCLK              (clk),
    .i_Reset_all         (rst),
    .i_tx_start          (start),
    .i_frame_length      (len),
    .i_write_busy        (wbusy),
    .o_start_read        (sreq),
    .o_byte_read_pointer (ptr),
    .o_Reset_Read        (rr),
    .i_read_data_ready   (rdy),
    .i_read_data         (rdata),
    .o_tx_bit            (tx_bit),
    .o_tx_enable         (tx_en),
    .o_busy              (busy),
    .o_done              (done),
    .o_error             (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM read port: ready rises after a per-address number of falling edges, cleared by Reset_Read low.
  always @(negedge clk) begin
    if (!rr) begin
      rdy  <= 1'b0;
      rcnt <= 0;
    end else if (sreq && !rdy && !no_ready) begin
      if (rcnt + 1 >= ((ptr == 13'd1) ? dly1 : 1)) begin
        rdy   <= 1'b1;
        rdata <= mem[ptr[0]];
      end
      rcnt <= rcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (tx_en === 1'b1) bits_q.push_back(tx_bit);
    if (done === 1'b1) n_done <= n_done + 1;
    if (err === 1'b1) n_err <= n_err + 1;
    if (sreq === 1'b1 && sreq_prev !== 1'b1) req_q.push_back(int'(ptr));
    sreq_prev <= sreq;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete AA AA 5A C3 frame; optional start poke mid-frame and restart around o_done.
  task automatic run_frame(input string tag, input bit started, input bit poke, input bit restart);
    int b0, r0, d0, c1;
    bit stable;
    logic [7:0] ob;
    logic [31:0] exp_w;
    exp_w = 32'hAAAA5AC3;
    b0 = bits_q.size();
    r0 = req_q.size();
    d0 = n_done;
    if (!started) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    c1 = cyc;
    chk({tag, "_first"}, {tx_en, tx_bit, busy, sreq, ptr == 13'd0}, 32'h1F);
    for (int k = 0; k < 300 && done !== 1'b1; k++) begin
      start = (poke && k == 20);
      step();
    end
    start = 1'b0;
    chk({tag, "_done"}, {done, tx_en, tx_bit, busy}, 32'h9);
    chk({tag, "_enable_len"}, cyc - c1, 32'd128);
    chk({tag, "_nbits"}, bits_q.size() - b0, 32'd128);
    if (bits_q.size() - b0 >= 128) begin
      for (int j = 0; j < 4; j++) begin
        stable = 1'b1;
        for (int k = 0; k < 8; k++) begin
          ob[7-k] = bits_q[b0 + (j*8 + k)*4];
          for (int m = 1; m < 4; m++)
            if (bits_q[b0 + (j*8 + k)*4 + m] != ob[7-k]) stable = 1'b0;
        end
        chk({tag, "_byte"}, {stable, ob}, {1'b1, exp_w[31-8*j -: 8]});
      end
    end
    chk({tag, "_nreq"}, req_q.size() - r0, 32'd2);
    if (req_q.size() - r0 == 2) chk({tag, "_addrs"}, {req_q[r0], req_q[r0+1]}, {32'd0, 32'd1});
    if (restart) begin
      start = 1'b1;
      step();
      chk("start_in_done_ignored", {busy, done}, 32'd0);
      step();
      start = 1'b0;
      chk("start_after_done_accepted", busy, 32'd1);
    end else begin
      step();
      chk({tag, "_idle_after"}, {busy, done}, 32'd0);
    end
    chk({tag, "_one_done"}, n_done - d0, 32'd1);
  endtask

  initial begin
    int c1, r0, d0, e0;
    rst = 1'b1; start = 1'b0; wbusy = 1'b0; len = 13'd2;
    step(); step();
    chk("reset_outs", outs, 32'd0);
    rst = 1'b0;
    step();

    run_frame("frame", 1'b0, 1'b0, 1'b0);

    // Refused starts.
    r0 = req_q.size(); d0 = n_done; e0 = n_err;
    wbusy = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("wbusy_ignored", busy, 32'd0);
    wbusy = 1'b0; len = 13'd0; start = 1'b1; step(); start = 1'b0;
    chk("len0_ignored", busy, 32'd0);
    len = 13'd2; step(); step();
    chk("ignored_quiet", outs, 32'd0);
    chk("ignored_no_activity", (req_q.size() - r0) + (n_done - d0) + (n_err - e0), 32'd0);

    // Read timeout.
    no_ready = 1'b1; d0 = n_done;
    start = 1'b1; step(); start = 1'b0; c1 = cyc;
    chk("to_req", {sreq, rr}, 32'd3);
    for (int k = 0; k < 200 && err !== 1'b1; k++) step();
    chk("to_error_seen", err, 32'd1);
    chk("to_latency", cyc - c1, 32'd64);
    chk("to_enable_in_err", tx_en, 32'd1);
    step();
    chk("to_abort_outs", outs, 32'd0);
    chk("to_no_done", n_done - d0, 32'd0);
    no_ready = 1'b0;
    step();

    // Reset in payload byte 1, bit 3.
    d0 = n_done; e0 = n_err;
    start = 1'b1; step(); start = 1'b0;
    repeat (108) step();
    chk("mid_state", {tx_en, busy, tx_bit}, 32'h6);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_reset_outs", outs, 32'd0);
    step();
    chk("mid_no_pulse", (n_done - d0) + (n_err - e0), 32'd0);
    run_frame("after_reset", 1'b0, 1'b0, 1'b0);

    // Underrun: byte 1 arrives too late.
    dly1 = 40; d0 = n_done; r0 = req_q.size();
    start = 1'b1; step(); start = 1'b0; c1 = cyc;
    for (int k = 0; k < 200 && err !== 1'b1; k++) step();
    chk("ur_error_seen", err, 32'd1);
    chk("ur_latency", cyc - c1, 32'd96);
    step();
    chk("ur_abort_outs", outs, 32'd0);
    chk("ur_no_done", n_done - d0, 32'd0);
    chk("ur_nreq", req_q.size() - r0, 32'd2);
    dly1 = 1;
    step(); step();

    // Start while busy, in the done cycle, and one cycle later.
    run_frame("busy_poke", 1'b0, 1'b1, 1'b1);
    run_frame("restart", 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
